boot_loader: RTL and testbench

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/boot_loader.sv | 96 +++++++++
 tb/tb_boot_loader.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// boot_loader: serial program loader that holds the CPU in reset and writes framed words to program memory
module boot_loader #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 2700000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              boot_mode,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic [ADDR_W:0]   cpu_pc,
  output logic              cpu_rst_n,
  output logic [15:0]       cpu_dout,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam logic [3:0] IDLE = 4'd0, RUN = 4'd1, HDR = 4'd2, LEN = 4'd3, LO = 4'd4,
                         HI = 4'd5, CSUM = 4'd6, DONE = 4'd7, ERR = 4'd8;
  localparam int IW = $clog2(TIMEOUT + 1);
  logic [3:0]        state, next;
  logic [8:0]        cnt;
  logic [ADDR_W-1:0] ptr;
  logic [7:0]        sum, lo;
  logic [15:0]       wdata;
  logic [IW-1:0]     idle;
  logic              loading, tout, is_hdr, pc_unused;
  assign loading   = state >= LEN && state <= CSUM;
  assign tout      = loading && !rx_valid && idle == IW'(TIMEOUT - 1);
  assign is_hdr    = rx_valid && rx_data == 8'hA5;
  assign pc_unused = cpu_pc[0];
  assign cpu_dout  = mem_rdata;
  assign mem_wdata = wdata;
  // the write cycle may land in the state after HI, so it keeps the pointer on the bus
  assign mem_addr  = (loading || mem_we) ? ptr : cpu_pc[ADDR_W:1];
  // next-state: aborts (boot_mode drop, byte timeout) take priority over byte handling
  always_comb begin
    next = state;
    if (loading && (!boot_mode || tout))
      next = ERR;
    else
      case (state)
        IDLE:    next = boot_mode ? HDR : RUN;
        RUN:     next = boot_mode ? HDR : RUN;
        HDR:     next = !boot_mode ? RUN : is_hdr ? LEN : HDR;
        LEN:     next = rx_valid ? LO : LEN;
        LO:      next = rx_valid ? HI : LO;
        HI:      next = !rx_valid ? HI : cnt == 9'd1 ? CSUM : LO;
        CSUM:    next = !rx_valid ? CSUM : rx_data == sum ? DONE : ERR;
        DONE:    next = boot_mode ? DONE : RUN;
        ERR:     next = (is_hdr && boot_mode) ? LEN : ERR;
        default: next = IDLE;
      endcase
  end
  // state, registered status outputs and load datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cpu_rst_n <= 1'b0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      ptr       <= '0;
      sum       <= '0;
      idle      <= '0;
      cnt       <= '0;
      lo        <= '0;
      wdata     <= '0;
    end else begin
      state     <= next;
      cpu_rst_n <= next == RUN;
      busy      <= next >= HDR && next <= CSUM;
      done      <= next == DONE ? 1'b1 : next == LEN ? 1'b0 : done;
      err       <= next == ERR ? 1'b1 : next == LEN ? 1'b0 : err;
      mem_we    <= state == HI && rx_valid && next != ERR;
      idle      <= (loading && !rx_valid) ? idle + IW'(1) : '0;
      if (mem_we) ptr <= ptr + ADDR_W'(1);
      if (state == LEN && rx_valid) begin
        cnt <= rx_data == 8'd0 ? 9'd256 : {1'b0, rx_data};
        ptr <= '0;
        sum <= '0;
      end
      if ((state == LO || state == HI) && rx_valid) sum <= sum + rx_data;
      if (state == LO && rx_valid) lo <= rx_data;
      if (state == HI && rx_valid) begin
        wdata <= {rx_data, lo};
        cnt   <= cnt - 9'd1;
      end
    end
  end
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed streams with a write scoreboard checked by an independent monitor
module tb_boot_loader;
  localparam int AW = 10;
  logic          clk = 0, rst_n = 0, boot_mode = 0, rx_valid = 0;
  logic [7:0]    rx_data = 0;
  logic [AW:0]   cpu_pc = 0;
  logic          cpu_rst_n, mem_we, busy, done, err;
  logic [15:0]   cpu_dout, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem [0:1023];
  logic [31:0]   exp_q[$];
  int            checks = 0, passes = 0;
  logic [7:0]    good [7] = '{8'hA5, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h14};
  logic [7:0]    sum;
  logic [7:0]    lo, hi;

  assign mem_rdata = mem[mem_addr];

  boot_loader #(.ADDR_W(AW), .TIMEOUT(100)) dut (
    .clk(clk), .rst_n(rst_n), .boot_mode(boot_mode), .rx_valid(rx_valid), .rx_data(rx_data),
    .cpu_pc(cpu_pc), .cpu_rst_n(cpu_rst_n), .cpu_dout(cpu_dout), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 0;
  endtask

  task automatic send_stream(input logic [7:0] csum);
    for (int i = 0; i < 6; i++) send(good[i]);
    send(csum);
  endtask

  task automatic push(input int a, input logic [15:0] d);
    exp_q.push_back({6'd0, 10'(a), d});
  endtask

  always @(negedge clk) begin
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected write: got addr %h data %h expected none", mem_addr, mem_wdata);
      end else chk("write", {6'd0, mem_addr, mem_wdata}, exp_q.pop_front());
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
    #3;
    chk("rst cpu_rst_n", 32'(cpu_rst_n), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst err", 32'(err), 0);
    chk("rst mem_we", 32'(mem_we), 0);
    @(negedge clk);
    rst_n = 1;
    cyc(2);
    chk("run cpu_rst_n", 32'(cpu_rst_n), 1);
    cpu_pc = 11'h006;
    mem[3] = 16'hBEEF;
    #1;
    chk("run mem_addr", 32'(mem_addr), 3);
    chk("run cpu_dout", 32'(cpu_dout), 32'hBEEF);
    boot_mode = 1;
    cyc(2);
    chk("hdr busy", 32'(busy), 1);
    chk("hdr cpu_rst_n", 32'(cpu_rst_n), 0);
    push(0, 16'h1234);
    push(1, 16'h5678);
    send_stream(8'h14);
    cyc(1);
    chk("load1 done", 32'(done), 1);
    chk("load1 busy", 32'(busy), 0);
    boot_mode = 0;
    cyc(2);
    chk("load1 run", 32'(cpu_rst_n), 1);
    boot_mode = 1;
    cyc(2);
    push(0, 16'h1234);
    push(1, 16'h5678);
    send_stream(8'h15);
    cyc(2);
    chk("bad err", 32'(err), 1);
    chk("bad done", 32'(done), 0);
    chk("bad cpu_rst_n", 32'(cpu_rst_n), 0);
    push(0, 16'h1234);
    push(1, 16'h5678);
    send_stream(8'h14);
    cyc(1);
    chk("retry done", 32'(done), 1);
    chk("retry err", 32'(err), 0);
    boot_mode = 0;
    cyc(2);
    boot_mode = 1;
    cyc(2);
    send(8'hA5);
    send(8'h00);
    sum = 0;
    for (int i = 0; i < 256; i++) begin
      lo = 8'(i);
      hi = 8'(i) ^ 8'h5A;
      push(i, {hi, lo});
      sum = sum + lo + hi;
      send(lo);
      send(hi);
    end
    send(sum);
    cyc(2);
    chk("full done", 32'(done), 1);
    chk("full writes drained", 32'(exp_q.size()), 0);
    boot_mode = 0;
    cyc(2);
    boot_mode = 1;
    cyc(2);
    send(8'hA5);
    send(8'h02);
    send(8'h34);
    cyc(90);
    chk("tout still busy", 32'(busy), 1);
    cyc(15);
    chk("tout err", 32'(err), 1);
    chk("tout busy", 32'(busy), 0);
    chk("tout cpu_rst_n", 32'(cpu_rst_n), 0);
    #2 rst_n = 0;
    #1 chk("rst2 err", 32'(err), 0);
    @(negedge clk);
    rst_n = 1;
    cyc(2);
    push(0, 16'hBBAA);
    send(8'h00);
    send(8'hFF);
    send(8'hA5);
    send(8'h01);
    send(8'hAA);
    send(8'hBB);
    send(8'h65);
    cyc(1);
    chk("noise done", 32'(done), 1);
    boot_mode = 0;
    cyc(2);
    boot_mode = 1;
    cyc(2);
    send(8'hA5);
    send(8'h01);
    send(8'hAA);
    cyc(3);
    #2 rst_n = 0;
    #1;
    chk("abort busy", 32'(busy), 0);
    chk("abort cpu_rst_n", 32'(cpu_rst_n), 0);
    chk("abort mem_we", 32'(mem_we), 0);
    chk("abort done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1;
    boot_mode = 0;
    send(8'hBB);
    cyc(3);
    chk("abort run", 32'(cpu_rst_n), 1);
    chk("final queue empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
